// File: rtl/npc_unit.sv
// npc_unit: F-stage PC register and D-stage branch/jump/jr resolution with
// redirect counter. Optional misaligned-fetch flag under NPC_ALIGN_CHECK_EN.
module npc_unit #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              F_en,
  input  logic              D_valid,
  input  logic [ADDR_W-1:0] D_pc,
  input  logic [15:0]       D_imm16,
  input  logic [25:0]       D_imm26,
  input  logic [31:0]       D_rs_val,
  input  logic [31:0]       D_rt_val,
  input  logic [2:0]        D_br_op,
  input  logic              D_jump,
  input  logic              D_jr,
  input  logic              cnt_clr,
  output logic [ADDR_W-1:0] F_pc,
  output logic              D_redirect,
  output logic [ADDR_W-1:0] D_link_addr,
  output logic [CNT_W-1:0]  redirect_cnt,
  output logic              F_adel
);

  localparam logic [ADDR_W-1:0] LP_RST   = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LP_FOUR  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] LP_EIGHT = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] LP_ALIGN = ~(ADDR_W'(3));
  localparam logic [CNT_W-1:0]  LP_CMAX  = '1;

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_cnt;

  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_j_tgt;
  logic [ADDR_W-1:0] w_jr_raw;
  logic [ADDR_W-1:0] w_jr_tgt;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_next;
  logic signed [31:0] w_rs_s;
  logic              w_br_true;
  logic              w_redirect;

  assign w_br_off = {{(ADDR_W-18){D_imm16[15]}}, D_imm16, 2'b00};
  assign w_br_tgt = D_pc + LP_FOUR + w_br_off;

  generate
    if (ADDR_W > 28) begin : g_jhi
      assign w_j_tgt = {D_pc[ADDR_W-1:28], D_imm26, 2'b00};
    end else begin : g_jlo
      assign w_j_tgt = {D_imm26, 2'b00};
    end
  endgenerate

  assign w_jr_raw = D_rs_val[ADDR_W-1:0];
`ifdef NPC_ALIGN_CHECK_EN
  assign w_jr_tgt = w_jr_raw;
`else
  assign w_jr_tgt = w_jr_raw & LP_ALIGN;
`endif

  assign w_rs_s = $signed(D_rs_val);

  // Branch condition decode; 0 and 7 are never taken.
  always_comb begin
    w_br_true = 1'b0;
    case (D_br_op)
      3'd1:    w_br_true = (D_rs_val == D_rt_val);
      3'd2:    w_br_true = (D_rs_val != D_rt_val);
      3'd3:    w_br_true = (w_rs_s <= 32'sd0);
      3'd4:    w_br_true = (w_rs_s > 32'sd0);
      3'd5:    w_br_true = (w_rs_s < 32'sd0);
      3'd6:    w_br_true = (w_rs_s >= 32'sd0);
      default: w_br_true = 1'b0;
    endcase
  end

  assign w_redirect = D_valid & (D_jr | D_jump | w_br_true);

  // Target select: jr wins over jump, jump over branch.
  always_comb begin
    w_tgt = w_br_tgt;
    if (D_jr) begin
      w_tgt = w_jr_tgt;
    end else if (D_jump) begin
      w_tgt = w_j_tgt;
    end
  end

  assign w_next = w_redirect ? w_tgt : (r_pc + LP_FOUR);

  // Fetch PC register; a stall freezes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= LP_RST;
    end else if (F_en) begin
      r_pc <= w_next;
    end
  end

  // Saturating redirect counter; clear wins and ignores stall.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      r_cnt <= '0;
    end else if (F_en && w_redirect && (r_cnt != LP_CMAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef NPC_ALIGN_CHECK_EN
  logic r_adel;

  // Misaligned-fetch flag follows the PC that is being loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_adel <= 1'b0;
    end else if (F_en) begin
      r_adel <= (w_next[1:0] != 2'b00);
    end
  end

  assign F_adel = r_adel;
`else
  assign F_adel = 1'b0;
`endif

  assign F_pc         = r_pc;
  assign D_redirect   = w_redirect;
  assign D_link_addr  = D_pc + LP_EIGHT;
  assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_npc_unit.sv
// tb_npc_unit: directed scenarios plus randomized cycles against a
// behavioural next-PC model; a CNT_W=2 copy checks counter saturation.
module tb_npc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        F_en;
  logic        D_valid;
  logic [31:0] D_pc;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  logic [31:0] D_rs_val;
  logic [31:0] D_rt_val;
  logic [2:0]  D_br_op;
  logic        D_jump;
  logic        D_jr;
  logic        cnt_clr;

  logic [31:0] F_pc;
  logic        D_redirect;
  logic [31:0] D_link_addr;
  logic [15:0] redirect_cnt;
  logic        F_adel;

  logic [31:0] F_pc2;
  logic        D_redirect2;
  logic [31:0] D_link_addr2;
  logic [1:0]  redirect_cnt2;
  logic        F_adel2;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  int          m_cnt;
  int          m_cnt2;
  logic        m_adel;
  logic        e_redir;
  logic [31:0] e_next;

`ifdef NPC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  npc_unit #(.ADDR_W(32), .RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .F_en(F_en), .D_valid(D_valid),
    .D_pc(D_pc), .D_imm16(D_imm16), .D_imm26(D_imm26),
    .D_rs_val(D_rs_val), .D_rt_val(D_rt_val), .D_br_op(D_br_op),
    .D_jump(D_jump), .D_jr(D_jr), .cnt_clr(cnt_clr),
    .F_pc(F_pc), .D_redirect(D_redirect), .D_link_addr(D_link_addr),
    .redirect_cnt(redirect_cnt), .F_adel(F_adel)
  );

  npc_unit #(.ADDR_W(32), .RESET_PC(32'h0000_3000), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .F_en(F_en), .D_valid(D_valid),
    .D_pc(D_pc), .D_imm16(D_imm16), .D_imm26(D_imm26),
    .D_rs_val(D_rs_val), .D_rt_val(D_rt_val), .D_br_op(D_br_op),
    .D_jump(D_jump), .D_jr(D_jr), .cnt_clr(cnt_clr),
    .F_pc(F_pc2), .D_redirect(D_redirect2), .D_link_addr(D_link_addr2),
    .redirect_cnt(redirect_cnt2), .F_adel(F_adel2)
  );

  function automatic void model_comb();
    int          rs_s;
    int          simm;
    bit          br;
    logic [31:0] t;
    rs_s = $signed(D_rs_val);
    simm = $signed(D_imm16);
    case (D_br_op)
      3'd1:    br = (D_rs_val == D_rt_val);
      3'd2:    br = (D_rs_val != D_rt_val);
      3'd3:    br = (rs_s <= 0);
      3'd4:    br = (rs_s > 0);
      3'd5:    br = (rs_s < 0);
      3'd6:    br = (rs_s >= 0);
      default: br = 1'b0;
    endcase
    e_redir = D_valid && (D_jr || D_jump || br);
    if (D_jr) begin
      t = D_rs_val;
      if (!ALIGN_EN) t = t - (t % 4);
    end else if (D_jump) begin
      t = (D_pc & 32'hF000_0000) + ({6'b0, D_imm26} * 4);
    end else begin
      t = D_pc + 32'd4 + 32'(simm * 4);
    end
    e_next = e_redir ? t : m_pc + 32'd4;
  endfunction

  task automatic tick();
    model_comb();
    if (reset) begin
      m_pc   = 32'h0000_3000;
      m_cnt  = 0;
      m_cnt2 = 0;
      m_adel = 1'b0;
    end else begin
      if (F_en) begin
        m_pc   = e_next;
        m_adel = ALIGN_EN && (e_next % 4 != 0);
      end
      if (cnt_clr) begin
        m_cnt  = 0;
        m_cnt2 = 0;
      end else if (F_en && e_redir) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; F_en = 1; D_valid = 1; D_pc = 32'h0;
    D_imm16 = 0; D_imm26 = 0; D_rs_val = 0; D_rt_val = 0;
    D_br_op = 0; D_jump = 0; D_jr = 0; cnt_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; F_en = 0; cnt_clr = 1;
    tick();
    tick();
    reset = 0;
    checks++;
    if (F_pc !== 32'h3000 || redirect_cnt !== 16'd0 || F_adel !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h cnt=%0d adel=%b want 3000 0 0",
               F_pc, redirect_cnt, F_adel);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    idle();
    exp_pc = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      checks++;
      if (F_pc !== exp_pc || redirect_cnt !== 16'd0) begin
        errors++;
        $display("FAIL seq%0d: pc=%h cnt=%0d want %h 0",
                 i, F_pc, redirect_cnt, exp_pc);
      end
    end
  endtask

  task automatic test_beq();
    idle();
    D_pc = 32'h3004; D_br_op = 3'd1; D_rs_val = 5; D_rt_val = 5;
    D_imm16 = 16'hFFFE;
    #1;
    checks++;
    if (D_redirect !== 1'b1) begin
      errors++;
      $display("FAIL beq_taken_comb: redirect=%b want 1", D_redirect);
    end
    tick();
    checks++;
    if (F_pc !== 32'h3000 || redirect_cnt !== 16'd1) begin
      errors++;
      $display("FAIL beq_taken: pc=%h cnt=%0d want 3000 1",
               F_pc, redirect_cnt);
    end
    D_rt_val = 6;
    #1;
    checks++;
    if (D_redirect !== 1'b0) begin
      errors++;
      $display("FAIL beq_not_comb: redirect=%b want 0", D_redirect);
    end
    tick();
    checks++;
    if (F_pc !== 32'h3004 || redirect_cnt !== 16'd1) begin
      errors++;
      $display("FAIL beq_not: pc=%h cnt=%0d want 3004 1",
               F_pc, redirect_cnt);
    end
  endtask

  task automatic test_branch_signs();
    idle();
    F_en = 0;
    D_br_op = 3'd5; D_rs_val = 32'h8000_0000;
    #1;
    checks++;
    if (D_redirect !== 1'b1) begin
      errors++;
      $display("FAIL bltz_neg: redirect=%b want 1", D_redirect);
    end
    D_br_op = 3'd4; D_rs_val = 32'h0;
    #1;
    checks++;
    if (D_redirect !== 1'b0) begin
      errors++;
      $display("FAIL bgtz_zero: redirect=%b want 0", D_redirect);
    end
    D_br_op = 3'd3;
    #1;
    checks++;
    if (D_redirect !== 1'b1) begin
      errors++;
      $display("FAIL blez_zero: redirect=%b want 1", D_redirect);
    end
    D_br_op = 3'd7;
    #1;
    checks++;
    if (D_redirect !== 1'b0) begin
      errors++;
      $display("FAIL br_reserved: redirect=%b want 0", D_redirect);
    end
    D_br_op = 3'd3; D_valid = 0;
    #1;
    checks++;
    if (D_redirect !== 1'b0) begin
      errors++;
      $display("FAIL bubble: redirect=%b want 0", D_redirect);
    end
  endtask

  task automatic test_jump();
    idle();
    D_pc = 32'h3000; D_jump = 1; D_imm26 = 26'h0000C40;
    #1;
    checks++;
    if (D_link_addr !== 32'h3008 || D_redirect !== 1'b1) begin
      errors++;
      $display("FAIL jump_link: link=%h redir=%b want 3008 1",
               D_link_addr, D_redirect);
    end
    tick();
    checks++;
    if (F_pc !== 32'h0000_3100) begin
      errors++;
      $display("FAIL jump: pc=%h want 00003100", F_pc);
    end
  endtask

  task automatic test_jr_priority();
    logic [31:0] exp_pc;
    logic        exp_adel;
    idle();
    D_pc = 32'h3100; D_jr = 1; D_jump = 1; D_imm26 = 26'h123;
    D_rs_val = 32'h3012;
    exp_pc   = ALIGN_EN ? 32'h3012 : 32'h3010;
    exp_adel = ALIGN_EN;
    tick();
    checks++;
    if (F_pc !== exp_pc || F_adel !== exp_adel) begin
      errors++;
      $display("FAIL jr_prio: pc=%h adel=%b want %h %b",
               F_pc, F_adel, exp_pc, exp_adel);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    logic [15:0] cnt0;
    idle();
    D_pc = 32'h3100; D_br_op = 3'd1; D_rs_val = 9; D_rt_val = 9;
    D_imm16 = 16'h0010;
    F_en = 0;
    #1;
    pc0  = F_pc;
    cnt0 = redirect_cnt;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (F_pc !== pc0 || redirect_cnt !== cnt0) begin
        errors++;
        $display("FAIL stall%0d: pc=%h cnt=%0d want %h %0d",
                 i, F_pc, redirect_cnt, pc0, cnt0);
      end
    end
    F_en = 1;
    tick();
    checks++;
    if (F_pc !== 32'h3144 || redirect_cnt !== cnt0 + 16'd1) begin
      errors++;
      $display("FAIL stall_release: pc=%h cnt=%0d want 3144 %0d",
               F_pc, redirect_cnt, cnt0 + 16'd1);
    end
  endtask

  task automatic test_saturation();
    idle();
    cnt_clr = 1;
    tick();
    checks++;
    if (redirect_cnt !== 16'd0 || redirect_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_clear: cnt=%0d cnt2=%0d want 0 0",
               redirect_cnt, redirect_cnt2);
    end
    cnt_clr = 0; D_jump = 1; D_imm26 = 26'h0000C40;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (redirect_cnt !== 16'd5 || redirect_cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL cnt_sat: cnt=%0d cnt2=%0d want 5 3",
               redirect_cnt, redirect_cnt2);
    end
    cnt_clr = 1;
    tick();
    checks++;
    if (redirect_cnt !== 16'd0 || redirect_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_clr_prio: cnt=%0d cnt2=%0d want 0 0",
               redirect_cnt, redirect_cnt2);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    D_jump = 1; D_imm26 = 26'h3FF_FFFF; F_en = 0;
    tick();
    F_en = 1; reset = 1;
    tick();
    checks++;
    if (F_pc !== 32'h3000 || redirect_cnt !== 16'd0 || F_adel !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: pc=%h cnt=%0d adel=%b want 3000 0 0",
               F_pc, redirect_cnt, F_adel);
    end
    reset = 0;
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 400; i++) begin
      r        = $urandom;
      reset    = ($urandom_range(0, 63) == 0);
      cnt_clr  = ($urandom_range(0, 31) == 0);
      F_en     = ($urandom_range(0, 3) != 0);
      D_valid  = ($urandom_range(0, 7) != 0);
      D_pc     = (r[0] ? 32'hFFFF_FFF0 : $urandom) & 32'hFFFF_FFFC;
      D_imm16  = 16'($urandom);
      D_imm26  = 26'($urandom);
      D_br_op  = 3'($urandom_range(0, 7));
      D_jump   = ($urandom_range(0, 7) == 0);
      D_jr     = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       D_rs_val = 32'h0;
        1:       D_rs_val = 32'h8000_0000 | $urandom;
        default: D_rs_val = $urandom;
      endcase
      D_rt_val = r[1] ? D_rs_val : $urandom;
      #1;
      model_comb();
      checks++;
      if (D_redirect !== e_redir || D_link_addr !== D_pc + 32'd8) begin
        errors++;
        $display("FAIL rnd_comb%0d: redir=%b link=%h want %b %h",
                 i, D_redirect, D_link_addr, e_redir, D_pc + 32'd8);
      end
      tick();
      checks++;
      if (F_pc !== m_pc || redirect_cnt !== 16'(m_cnt) ||
          redirect_cnt2 !== 2'(m_cnt2) || F_adel !== m_adel) begin
        errors++;
        $display("FAIL rnd%0d: pc=%h cnt=%0d cnt2=%0d adel=%b want %h %0d %0d %b",
                 i, F_pc, redirect_cnt, redirect_cnt2, F_adel,
                 m_pc, m_cnt, m_cnt2, m_adel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_beq();
    test_branch_signs();
    test_jump();
    test_jr_priority();
    test_stall();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
